// File: rtl/dispatch_source_staged.sv
// Command decoder staging per-input spike charge and releasing it on RUN; one-cycle registered update.
// Backpressure: NOP/SPK always accepted; RUN/CLR held until the final pending network cycle is consumed.
module dispatch_source_staged #(
  parameter int NUM_INP      = 8,
  parameter int CHARGE_WIDTH = 8,
  parameter int RUN_WIDTH    = 16,
  parameter int ACCUM        = 0,
  localparam int OPC_WIDTH   = 2,
  localparam int IDX_WIDTH   = (NUM_INP > 1) ? $clog2(NUM_INP) : 0,
  localparam int PAY_WIDTH   = (RUN_WIDTH > IDX_WIDTH + CHARGE_WIDTH) ? RUN_WIDTH
                                                                       : IDX_WIDTH + CHARGE_WIDTH,
  localparam int SRC_WIDTH   = OPC_WIDTH + PAY_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              src_valid,
  output logic                              src_ready,
  input  logic [SRC_WIDTH-1:0]              src,
  input  logic                              net_ready,
  output logic                              net_valid,
  output logic                              net_rst,
  output logic [NUM_INP*CHARGE_WIDTH-1:0]   net_inp,
  output logic                              err_idx,
  output logic                              sat
);

  localparam int IDX_W1 = (IDX_WIDTH > 0) ? IDX_WIDTH : 1;
  localparam logic [1:0] OPC_NOP = 2'd0;
  localparam logic [1:0] OPC_RUN = 2'd1;
  localparam logic [1:0] OPC_SPK = 2'd2;
  localparam logic [1:0] OPC_CLR = 2'd3;

  logic [RUN_WIDTH-1:0]           r_run_cnt;
  logic signed [CHARGE_WIDTH-1:0] r_stg [NUM_INP];
  logic signed [CHARGE_WIDTH-1:0] r_net [NUM_INP];

  logic [1:0]              w_opc;
  logic [RUN_WIDTH-1:0]    w_run;
  logic [IDX_W1-1:0]       w_idx;
  logic [CHARGE_WIDTH-1:0] w_chg;
  logic                    w_idx_ok;
  logic                    w_done;
  logic                    w_ctl_rdy;
  logic                    w_acc;
  logic [CHARGE_WIDTH-1:0] w_cur;
  logic [CHARGE_WIDTH:0]   w_sum;
  logic                    w_ovf;
  logic [CHARGE_WIDTH-1:0] w_sat_val;

  assign w_opc = src[SRC_WIDTH-1 -: OPC_WIDTH];
  assign w_run = src[SRC_WIDTH-3 -: RUN_WIDTH];
  assign w_chg = src[SRC_WIDTH-3-IDX_WIDTH -: CHARGE_WIDTH];

  generate
    if (IDX_WIDTH > 0) begin : g_idx
      assign w_idx = src[SRC_WIDTH-3 -: IDX_WIDTH];
    end else begin : g_noidx
      assign w_idx = '0;
    end
  endgenerate

  assign w_idx_ok  = (32'(w_idx) < NUM_INP);
  assign net_valid = (r_run_cnt != '0);
  assign w_done    = net_valid && net_ready;
  // Control commands wait until no network cycle would be left pending after this edge.
  assign w_ctl_rdy = (r_run_cnt == '0) || ((r_run_cnt == RUN_WIDTH'(1)) && net_ready);
  assign src_ready = ((w_opc == OPC_RUN) || (w_opc == OPC_CLR)) ? w_ctl_rdy : 1'b1;
  assign w_acc     = src_valid && src_ready;

  assign w_cur     = w_idx_ok ? r_stg[w_idx] : '0;
  assign w_sum     = {w_cur[CHARGE_WIDTH-1], w_cur} + {w_chg[CHARGE_WIDTH-1], w_chg};
  assign w_ovf     = w_sum[CHARGE_WIDTH] ^ w_sum[CHARGE_WIDTH-1];
  assign w_sat_val = !w_ovf ? w_sum[CHARGE_WIDTH-1:0]
                   : (w_sum[CHARGE_WIDTH] ? {1'b1, {(CHARGE_WIDTH-1){1'b0}}}
                                          : {1'b0, {(CHARGE_WIDTH-1){1'b1}}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_run_cnt <= '0;
      for (int i = 0; i < NUM_INP; i++) begin
        r_stg[i] <= '0;
        r_net[i] <= '0;
      end
      err_idx <= 1'b0;
      sat     <= 1'b0;
      net_rst <= 1'b1;
    end else begin
      err_idx <= 1'b0;
      sat     <= 1'b0;
      net_rst <= 1'b0;
      // Staged charge only drives the first cycle of a run.
      if (w_done) begin
        r_run_cnt <= r_run_cnt - RUN_WIDTH'(1);
        for (int i = 0; i < NUM_INP; i++) r_net[i] <= '0;
      end
      if (w_acc) begin
        case (w_opc)
          OPC_RUN: begin
            r_run_cnt <= (w_run == '0) ? RUN_WIDTH'(1) : w_run;
            for (int i = 0; i < NUM_INP; i++) begin
              r_net[i] <= r_stg[i];
              r_stg[i] <= '0;
            end
          end
          OPC_SPK: begin
            if (!w_idx_ok) begin
              err_idx <= 1'b1;
            end else if (ACCUM != 0) begin
              r_stg[w_idx] <= w_sat_val;
              sat          <= w_ovf;
            end else begin
              r_stg[w_idx] <= w_chg;
            end
          end
          OPC_CLR: begin
            net_rst   <= 1'b1;
            r_run_cnt <= '0;
            for (int i = 0; i < NUM_INP; i++) begin
              r_stg[i] <= '0;
              r_net[i] <= '0;
            end
          end
          OPC_NOP: ;
          default: ;
        endcase
      end
    end
  end

  generate
    for (genvar g = 0; g < NUM_INP; g++) begin : g_out
      assign net_inp[g*CHARGE_WIDTH +: CHARGE_WIDTH] = r_net[g];
    end
  endgenerate

endmodule

// File: tb/tb_dispatch_source_staged.sv
// Directed bench: one overwrite-mode instance (4 inputs) and one accumulate-mode instance (5 inputs).
module tb_dispatch_source_staged;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: NUM_INP=4, CW=8, RW=4, ACCUM=0 -> 12-bit command
  logic        v0, r0, nr0, nv0, nrst0, e0, sat0;
  logic [11:0] s0;
  logic [31:0] ni0;
  // Instance 1: NUM_INP=5, CW=8, RW=4, ACCUM=1 -> 13-bit command
  logic        v1, r1, nr1, nv1, nrst1, e1, sat1;
  logic [12:0] s1;
  logic [39:0] ni1;

  int vec_cnt = 0;
  int err_cnt = 0;

  dispatch_source_staged #(.NUM_INP(4), .CHARGE_WIDTH(8), .RUN_WIDTH(4), .ACCUM(0)) u_dut0 (
    .clk(clk), .rst(rst), .src_valid(v0), .src_ready(r0), .src(s0),
    .net_ready(nr0), .net_valid(nv0), .net_rst(nrst0), .net_inp(ni0),
    .err_idx(e0), .sat(sat0));

  dispatch_source_staged #(.NUM_INP(5), .CHARGE_WIDTH(8), .RUN_WIDTH(4), .ACCUM(1)) u_dut1 (
    .clk(clk), .rst(rst), .src_valid(v1), .src_ready(r1), .src(s1),
    .net_ready(nr1), .net_valid(nv1), .net_rst(nrst1), .net_inp(ni1),
    .err_idx(e1), .sat(sat1));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] c0_run(input logic [3:0] n);
    return {2'd1, n, 6'd0};
  endfunction
  function automatic logic [11:0] c0_spk(input logic [1:0] idx, input logic [7:0] ch);
    return {2'd2, idx, ch};
  endfunction
  function automatic logic [12:0] c1_run(input logic [3:0] n);
    return {2'd1, n, 7'd0};
  endfunction
  function automatic logic [12:0] c1_spk(input logic [2:0] idx, input logic [7:0] ch);
    return {2'd2, idx, ch};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send0(input logic [11:0] cmd);
    int n = 0;
    s0 = cmd; v0 = 1'b1;
    #1;
    while (!r0 && n < 50) begin @(negedge clk); #1; n++; end
    chk("accept0", r0, 1);
    @(posedge clk);
    @(negedge clk);
    v0 = 1'b0;
  endtask

  task automatic send1(input logic [12:0] cmd);
    int n = 0;
    s1 = cmd; v1 = 1'b1;
    #1;
    while (!r1 && n < 50) begin @(negedge clk); #1; n++; end
    chk("accept1", r1, 1);
    @(posedge clk);
    @(negedge clk);
    v1 = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    v0 = 0; nr0 = 0; s0 = '0;
    v1 = 0; nr1 = 1; s1 = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_nv", nv0, 0);
    chk("rst_nrst", nrst0, 1);
    chk("rst_inp", ni0, 0);
    chk("rst_err", e0, 0);
    chk("rst_sat", sat0, 0);
    s0 = c0_run(4'd3); #1; chk("rst_rdy_run", r0, 1);
    s0 = 12'hC00;      #1; chk("rst_rdy_clr", r0, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("nrst_release", nrst0, 0);

    // Staged spike lands on first run cycle only
    nr0 = 1;
    send0(c0_spk(2'd2, 8'h05));
    send0(c0_run(4'd3));
    chk("run3_c1_v", nv0, 1);
    chk("run3_c1_in2", ni0[23:16], 8'h05);
    @(negedge clk);
    chk("run3_c2_v", nv0, 1);
    chk("run3_c2_in2", ni0[23:16], 8'h00);
    @(negedge clk);
    chk("run3_c3_v", nv0, 1);
    chk("run3_c3_in", ni0, 0);
    @(negedge clk);
    chk("run3_end", nv0, 0);

    // Spike accepted during stalled run; next RUN held until the last cycle
    nr0 = 0;
    send0(c0_run(4'd4));
    send0(c0_spk(2'd1, 8'hF9));
    chk("stall_nv", nv0, 1);
    s0 = c0_run(4'd1); v0 = 1; #1;
    chk("run_held", r0, 0);
    nr0 = 1;
    send0(c0_run(4'd1));
    chk("run2_v", nv0, 1);
    chk("run2_in1", ni0[15:8], 8'hF9);
    @(negedge clk);
    chk("run2_end", nv0, 0);

    // RUN(0) gives exactly one cycle
    send0(c0_run(4'd0));
    chk("run0_v", nv0, 1);
    @(negedge clk);
    chk("run0_end", nv0, 0);

    // CLR on the final pending cycle
    send0(c0_spk(2'd0, 8'h22));
    nr0 = 0;
    send0(c0_run(4'd1));
    chk("clrlast_in0", ni0[7:0], 8'h22);
    s0 = 12'hC00; v0 = 1; #1;
    chk("clr_held", r0, 0);
    nr0 = 1; #1;
    chk("clr_ok", r0, 1);
    @(posedge clk);
    @(negedge clk);
    v0 = 0;
    chk("clrlast_nrst", nrst0, 1);
    chk("clrlast_nv", nv0, 0);
    chk("clrlast_in", ni0, 0);

    // CLR while idle wipes staged charge
    send0(c0_spk(2'd3, 8'h11));
    send0(12'hC00);
    chk("clr_nrst", nrst0, 1);
    chk("clr_in", ni0, 0);
    @(negedge clk);
    chk("clr_nrst_off", nrst0, 0);
    send0(c0_run(4'd1));
    chk("clr_stg", ni0, 0);
    @(negedge clk);

    // Reset mid-run aborts and discards staging
    nr0 = 0;
    send0(c0_spk(2'd1, 8'h33));
    send0(c0_run(4'd10));
    chk("rr_nv", nv0, 1);
    send0(c0_spk(2'd2, 8'h44));
    rst = 1;
    @(negedge clk);
    chk("rr_nv_off", nv0, 0);
    chk("rr_nrst", nrst0, 1);
    rst = 0;
    @(negedge clk);
    nr0 = 1;
    send0(c0_run(4'd1));
    chk("rr_stg", ni0, 0);

    // Maximum run length
    @(negedge clk);
    send0(c0_run(4'd15));
    n = 0;
    while (nv0 && n < 40) begin n++; @(negedge clk); end
    chk("run15_cnt", n, 15);

    // Saturating accumulate, positive clamp
    send1(c1_spk(3'd0, 8'h64));
    chk("acc1_nosat", sat1, 0);
    send1(c1_spk(3'd0, 8'h64));
    chk("acc1_sat", sat1, 1);
    @(negedge clk);
    chk("acc1_sat_pulse", sat1, 0);
    send1(c1_run(4'd1));
    chk("acc1_val", ni1[7:0], 8'h7F);
    @(negedge clk);

    // Saturating accumulate, negative clamp
    send1(c1_spk(3'd0, 8'h80));
    chk("acc2_nosat", sat1, 0);
    send1(c1_spk(3'd0, 8'hFF));
    chk("acc2_sat", sat1, 1);
    send1(c1_run(4'd1));
    chk("acc2_val", ni1[7:0], 8'h80);
    chk("acc2_sat_pulse", sat1, 0);
    @(negedge clk);

    // Out-of-range index leaves banks untouched
    send1(c1_spk(3'd1, 8'h12));
    send1(c1_spk(3'd6, 8'h55));
    chk("err_pulse", e1, 1);
    @(negedge clk);
    chk("err_off", e1, 0);
    send1(c1_spk(3'd4, 8'h07));
    chk("idx4_ok", e1, 0);
    send1(c1_run(4'd1));
    chk("err_bank", ni1, 40'h07_00_00_12_00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
